crc_frame_sched: RTL and testbench

- Round-robin scheduler that shares one serial CRC-8 engine (ports Data/Active in; CRC/Valid out) among NREQ requesters.
- Accepts a byte frame from the granted requester and serializes it LSB-first into the engine with Active held continuously high.
- Collects the 8 serial CRC bits the engine emits after Active falls, then returns them as a byte tagged with the requester ID.
- Sits between the packet-builder clients and the CRC engine instance; the engine shares this block's clk/rst.

---
 rtl/crc_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 51 +++++
 rtl/crc_frame_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_crc_frame_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_sched_pkg.sv
// Shared types and widths for the CRC frame scheduler and its arbiter.
package crc_sched_pkg;

  localparam int CRC_W     = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker: first requester at or after the pointer wins;
// the pointer moves past the served requester when advance pulses.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  input  logic [ID_W-1:0] served_idx,
  output logic            any_req,
  output logic [ID_W-1:0] pick_idx,
  output logic [NREQ-1:0] pick_onehot
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  int              idx;

  // Scan from the far end so the candidate closest to the pointer is written last.
  always_comb begin
    any_req     = 1'b0;
    pick_idx    = '0;
    idx         = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (req[idx]) begin
        any_req  = 1'b1;
        pick_idx = ID_W'(idx);
      end
    end
    pick_onehot = any_req ? (NREQ'(1) << pick_idx) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (served_idx == ID_W'(NREQ - 1)) ? '0 : ID_W'(served_idx + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/crc_frame_sched.sv
// Shares one serial CRC-8 engine among NREQ byte-frame sources: grants round-robin,
// streams the frame LSB-first with Active held high, then collects the 8 result bits.
module crc_frame_sched
  import crc_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int LEN_W = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ*8-1:0]     byte_data,
  input  logic [NREQ-1:0]       byte_valid,
  output logic [NREQ-1:0]       byte_ready,
  output logic [NREQ-1:0]       gnt,
  output logic                  crc_active,
  output logic                  crc_data,
  input  logic                  crc_bit,
  input  logic                  crc_valid,
  output logic                  res_valid,
  output logic [ID_W-1:0]       res_id,
  output logic [CRC_W-1:0]      res_crc,
  output logic                  res_err
);

  state_e                state_q, state_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [ID_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      bytes_left_q, bytes_left_d;
  logic [7:0]            shreg_q, shreg_d;
  logic [7:0]            hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [BIT_CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic                  err_q, err_d;
  logic [CRC_W-1:0]      cap_q, cap_d;
  logic                  cap_full_q, cap_full_d;
  logic                  res_valid_q, res_valid_d;
  logic [ID_W-1:0]       res_id_q, res_id_d;
  logic [CRC_W-1:0]      res_crc_q, res_crc_d;
  logic                  res_err_q, res_err_d;

  logic                  any_req;
  logic [ID_W-1:0]       pick_idx;
  logic [NREQ-1:0]       pick_onehot;
  logic                  advance;
  logic                  ready_en;
  logic                  take;
  logic [LEN_W-1:0]      pick_len;
  logic [7:0]            sel_data;
  logic                  sel_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .advance     (advance),
    .served_idx  (gnt_idx_q),
    .any_req     (any_req),
    .pick_idx    (pick_idx),
    .pick_onehot (pick_onehot)
  );

  assign pick_len  = req_len[pick_idx*LEN_W +: LEN_W];
  assign sel_data  = byte_data[gnt_idx_q*8 +: 8];
  assign sel_valid = byte_valid[gnt_idx_q];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign byte_ready[gi] = ready_en && (gnt_idx_q == ID_W'(gi));
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_idx_d    = gnt_idx_q;
    len_d        = len_q;
    bytes_left_d = bytes_left_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    bitcnt_d     = bitcnt_q;
    err_d        = err_q;
    cap_d        = cap_q;
    cap_full_d   = cap_full_q;
    res_valid_d  = 1'b0;
    res_id_d     = res_id_q;
    res_crc_d    = res_crc_q;
    res_err_d    = res_err_q;
    advance      = 1'b0;
    ready_en     = 1'b0;
    take         = 1'b0;
    crc_active   = 1'b0;
    crc_data     = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d       = pick_onehot;
          gnt_idx_d   = pick_idx;
          len_d       = pick_len;
          err_d       = 1'b0;
          cap_d       = '0;
          cap_full_d  = 1'b0;
          hold_full_d = 1'b0;
          bitcnt_d    = '0;
          if (pick_len == '0) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_id_d    = pick_idx;
            res_crc_d   = '0;
            res_err_d   = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        ready_en = 1'b1;
        if (sel_valid) begin
          shreg_d      = sel_data;
          bytes_left_d = len_q - 1'b1;
          bitcnt_d     = '0;
          state_d      = SHIFT;
        end
      end

      SHIFT: begin
        crc_active = 1'b1;
        crc_data   = shreg_q[0];
        ready_en   = !hold_full_q && (bytes_left_q != '0);
        take       = ready_en && sel_valid;
        shreg_d    = shreg_q >> 1;
        bitcnt_d   = bitcnt_q + 1'b1;
        if (take) begin
          hold_d      = sel_data;
          hold_full_d = 1'b1;
        end
        // A byte arriving on the last bit feeds straight through so the stream stays gapless.
        if (bitcnt_q == '1) begin
          if (bytes_left_q == '0) begin
            state_d = DRAIN;
          end else if (hold_full_q) begin
            shreg_d      = hold_q;
            hold_full_d  = 1'b0;
            bytes_left_d = bytes_left_q - 1'b1;
          end else if (take) begin
            shreg_d      = sel_data;
            hold_full_d  = 1'b0;
            bytes_left_d = bytes_left_q - 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (crc_valid && !cap_full_q) begin
          cap_d[bitcnt_q] = crc_bit;
          bitcnt_d        = bitcnt_q + 1'b1;
          if (bitcnt_q == '1) begin
            cap_full_d = 1'b1;
          end
        end else if (!crc_valid && cap_full_q) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_id_d    = gnt_idx_q;
          res_crc_d   = cap_q;
          res_err_d   = err_q;
        end
      end

      DONE: begin
        gnt_d   = '0;
        advance = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_idx_q    <= '0;
      len_q        <= '0;
      bytes_left_q <= '0;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      bitcnt_q     <= '0;
      err_q        <= 1'b0;
      cap_q        <= '0;
      cap_full_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_crc_q    <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_idx_q    <= gnt_idx_d;
      len_q        <= len_d;
      bytes_left_q <= bytes_left_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      bitcnt_q     <= bitcnt_d;
      err_q        <= err_d;
      cap_q        <= cap_d;
      cap_full_q   <= cap_full_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_crc_q    <= res_crc_d;
      res_err_q    <= res_err_d;
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_crc   = res_crc_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_crc_frame_sched.sv
// Bench for crc_frame_sched: serial CRC-8 engine stub (x^8+x^2+x+1, seed 0),
// byte-stream requesters, and a long-division reference checked every cycle.
module tb_crc_frame_sched;

  localparam int NREQ  = 4;
  localparam int LEN_W = 4;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ*8-1:0]     byte_data;
  logic [NREQ-1:0]       byte_valid;
  logic [NREQ-1:0]       byte_ready;
  logic [NREQ-1:0]       gnt;
  logic                  crc_active;
  logic                  crc_data;
  logic                  crc_bit;
  logic                  crc_valid;
  logic                  res_valid;
  logic [ID_W-1:0]       res_id;
  logic [7:0]            res_crc;
  logic                  res_err;

  always #5 clk = ~clk;

  crc_frame_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_len    (req_len),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .gnt        (gnt),
    .crc_active (crc_active),
    .crc_data   (crc_data),
    .crc_bit    (crc_bit),
    .crc_valid  (crc_valid),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_crc    (res_crc),
    .res_err    (res_err)
  );

  // Engine stub: accumulates while Active, then one cycle after Active falls
  // emits its register MSB-first for 8 cycles and reseeds.
  logic [7:0] eng_crc;
  logic       eng_act_d;
  logic       eng_emit;
  logic [2:0] eng_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_crc   <= '0;
      eng_act_d <= 1'b0;
      eng_emit  <= 1'b0;
      eng_cnt   <= '0;
    end else begin
      eng_act_d <= crc_active;
      if (crc_active) begin
        eng_crc <= {eng_crc[6:0], 1'b0} ^ ((eng_crc[7] ^ crc_data) ? 8'h07 : 8'h00);
      end else if (eng_emit) begin
        eng_crc <= {eng_crc[6:0], 1'b0};
        eng_cnt <= eng_cnt + 3'd1;
        if (eng_cnt == 3'd7) begin
          eng_emit <= 1'b0;
          eng_crc  <= '0;
        end
      end else if (eng_act_d) begin
        eng_emit <= 1'b1;
        eng_cnt  <= '0;
      end
    end
  end

  assign crc_bit   = eng_crc[7];
  assign crc_valid = eng_emit;

  typedef struct {
    int           id;
    int           nact;
    logic [127:0] bytes;
    logic         err;
    logic         chk;
    logic [7:0]   crc;
  } exp_t;

  exp_t         expq[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           act_cnt = 0;
  bit           fell = 0;
  logic [127:0] fbytes[NREQ];
  int           flen[NREQ];
  int           ptr[NREQ];
  int           gap_cfg[NREQ];
  int           gapc[NREQ];
  bit           en[NREQ];
  bit           fire_p[NREQ];

  // Remainder of M(x)*x^8 / (x^8+x^2+x+1) over the bits in wire order;
  // result bit k is the k-th remainder bit the engine sends.
  function automatic logic [7:0] model_crc(input logic [127:0] b, input int n);
    bit         msg [0:135];
    logic [8:0] poly;
    logic [7:0] r;
    poly = 9'h107;
    for (int i = 0; i < 136; i++) msg[i] = (i < n * 8) ? b[i] : 1'b0;
    for (int i = 0; i < n * 8; i++) begin
      if (msg[i]) begin
        for (int j = 0; j < 9; j++) msg[i + j] = msg[i + j] ^ poly[8 - j];
      end
    end
    for (int k = 0; k < 8; k++) r[k] = msg[n * 8 + k];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    check("ready_outside_gnt", 32'(byte_ready & ~gnt), 0);
    check("gnt_onehot", 32'(gnt & (gnt - 1'b1)), 0);
    if (expq.size() == 0) begin
      check("active_without_frame", 32'(crc_active), 0);
      check("res_unexpected", 32'(res_valid), 0);
    end else begin
      if (gnt != '0) check("gnt_id", 32'(gnt), 32'(1) << expq[0].id);
      if (crc_active) begin
        check("active_contig", 32'(fell), 0);
        if (act_cnt < 128) check("crc_data", 32'(crc_data), 32'(expq[0].bytes[act_cnt]));
        act_cnt++;
      end else if (act_cnt > 0) begin
        fell = 1;
      end
      if (res_valid) begin
        e = expq.pop_front();
        $display("result id=%0d crc=%02h err=%0b active_cycles=%0d", res_id, res_crc, res_err, act_cnt);
        check("res_id", 32'(res_id), 32'(e.id));
        check("res_err", 32'(res_err), 32'(e.err));
        check("active_cycles", act_cnt, e.nact);
        if (e.chk) check("res_crc", 32'(res_crc), 32'(e.crc));
        act_cnt = 0;
        fell    = 0;
      end
    end
  endtask

  task automatic feed();
    if (res_valid) begin
      req[res_id] = 1'b0;
      en[res_id]  = 1'b0;
    end
    for (int r = 0; r < NREQ; r++) begin
      if (fire_p[r]) begin
        ptr[r]++;
        gapc[r] = gap_cfg[r];
      end
      if (gapc[r] > 0) gapc[r]--;
      byte_valid[r]      = en[r] && (ptr[r] < flen[r]) && (gapc[r] == 0);
      byte_data[r*8 +: 8] = fbytes[r][(ptr[r] % 16) * 8 +: 8];
      fire_p[r]          = byte_valid[r] && byte_ready[r];
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    feed();
  endtask

  task automatic start(input int r, input int len, input logic [127:0] bytes, input int gap);
    fbytes[r]  = bytes;
    flen[r]    = len;
    ptr[r]     = 0;
    gapc[r]    = 0;
    gap_cfg[r] = gap;
    fire_p[r]  = 0;
    en[r]      = 1;
    req_len[r*LEN_W +: LEN_W] = LEN_W'(len);
    req[r]     = 1'b1;
  endtask

  task automatic expect_frame(input int id, input int nbytes, input logic err, input logic chk);
    exp_t e;
    e.id    = id;
    e.nact  = nbytes * 8;
    e.bytes = fbytes[id];
    e.err   = err;
    e.chk   = chk;
    e.crc   = model_crc(fbytes[id], nbytes);
    expq.push_back(e);
  endtask

  task automatic run_until_empty(input int budget, output int used);
    used = 0;
    while (expq.size() != 0 && used < budget) begin
      step();
      used++;
    end
    if (expq.size() != 0) begin
      check("timeout_pending", expq.size(), 0);
      expq.delete();
      act_cnt = 0;
      fell    = 0;
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_ready"}, 32'(byte_ready), 0);
    check({tag, "_active_data"}, 32'({crc_active, crc_data}), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_id_crc_err"}, 32'({res_id, res_crc, res_err}), 0);
  endtask

  task automatic clear_bench();
    expq.delete();
    act_cnt = 0;
    fell    = 0;
    for (int r = 0; r < NREQ; r++) begin
      en[r]     = 0;
      fire_p[r] = 0;
      ptr[r]    = 0;
      flen[r]   = 0;
    end
    req        = '0;
    byte_valid = '0;
  endtask

  initial begin
    int used;
    int cnt;
    logic [127:0] b;
    rst       = 1'b1;
    req       = '0;
    req_len   = '0;
    byte_data = '0;
    byte_valid = '0;
    clear_bench();
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_reset_outs("reset");
    rst = 1'b1;
    step();

    // Reference pins: 0xA5 and 0x01 sent LSB-first into CRC-8/0x07 seed 0.
    b = '0; b[7:0] = 8'hA5;
    check("model_pin_a5", 32'(model_crc(b, 1)), 32'h4E);
    b = '0; b[7:0] = 8'h01;
    check("model_pin_01", 32'(model_crc(b, 1)), 32'h91);

    // Single byte on requester 0
    b = '0; b[7:0] = 8'hA5;
    start(0, 1, b, 0);
    expect_frame(0, 1, 1'b0, 1'b1);
    step();
    check("grant_latency", 32'(gnt), 32'h1);
    run_until_empty(200, used);
    check("single_res_crc_literal", 32'(res_crc), 32'h4E);
    step();
    check("res_hold", 32'({res_id, res_crc, res_err}), 32'({2'd0, 8'h4E, 1'b0}));

    // Three contiguous bytes on requester 1
    b = '0; b[23:0] = 24'h030201;
    start(1, 3, b, 0);
    expect_frame(1, 3, 1'b0, 1'b1);
    run_until_empty(300, used);

    // Zero-length frame on requester 2
    start(2, 0, '0, 0);
    expect_frame(2, 0, 1'b1, 1'b1);
    run_until_empty(10, used);
    check("len0_latency_ok", 32'(used <= 3), 1);

    // Requester 3 single byte brings the pointer back to 0
    b = '0; b[7:0] = 8'h3C;
    start(3, 1, b, 0);
    expect_frame(3, 1, 1'b0, 1'b1);
    run_until_empty(200, used);

    // All four requesting: served 0,1,2,3
    for (int r = 0; r < NREQ; r++) begin
      b = '0; b[7:0] = 8'(8'h11 * (r + 1));
      start(r, 1, b, 0);
    end
    for (int r = 0; r < NREQ; r++) expect_frame(r, 1, 1'b0, 1'b1);
    run_until_empty(400, used);

    // req=1001 with pointer at 0: served 0 then 3
    b = '0; b[15:0] = 16'hC3_96;
    start(0, 2, b, 0);
    b = '0; b[7:0] = 8'hF0;
    start(3, 1, b, 0);
    expect_frame(0, 2, 1'b0, 1'b1);
    expect_frame(3, 1, 1'b0, 1'b1);
    run_until_empty(400, used);

    // Underrun: second byte offered 12 cycles after the first
    b = '0; b[15:0] = 16'h6677;
    start(1, 2, b, 12);
    expect_frame(1, 1, 1'b1, 1'b0);
    run_until_empty(200, used);
    b = '0; b[7:0] = 8'h5A;
    start(1, 1, b, 0);
    expect_frame(1, 1, 1'b0, 1'b1);
    run_until_empty(200, used);

    // Reset during SHIFT of a 4-byte frame
    b = '0; b[31:0] = 32'hEFBEADDE;
    start(2, 4, b, 0);
    expect_frame(2, 4, 1'b0, 1'b1);
    cnt = 0;
    while (!crc_active && cnt < 20) begin
      step();
      cnt++;
    end
    check("midframe_active_seen", 32'(crc_active), 1);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b0;
    #1;
    check_reset_outs("midreset");
    clear_bench();
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 30; i++) step();

    // Fresh frame after reset
    b = '0; b[7:0] = 8'hA5;
    start(0, 1, b, 0);
    expect_frame(0, 1, 1'b0, 1'b1);
    run_until_empty(200, used);
    check("post_reset_crc_literal", 32'(res_crc), 32'h4E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
